// File: rtl/ccd_timing_pkg.sv
// Shared definitions for the CCD vertical timing block.
// Contents: the FSM state encoding, the XV idle level, the 8-step 4-phase
// transfer pattern table, and the default interval lengths.
package ccd_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XSG_PRE,
    ST_XSG_ACT,
    ST_XSG_POST,
    ST_LINE_WAIT,
    ST_VSHIFT
  } state_t;

  localparam logic [3:0] XV_IDLE = 4'b1100;

  // Element 0 is the rightmost entry, so the table reads step 7 down to step 0.
  localparam logic [7:0][3:0] XV_PAT = {
    4'b1101, 4'b1001, 4'b1011, 4'b0011,
    4'b0111, 4'b0110, 4'b1110, 4'b1100
  };

  localparam int XV_STEP_DEF   = 4;
  localparam int XSG_WIDTH_DEF = 16;
  localparam int XSG_GUARD_DEF = 8;
  localparam int OFD_WIDTH_DEF = 32;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ccd_ofd_pulse.sv
// Trigger-to-fixed-width pulse generator for the overflow-drain shutter.
// Ports: clk, reset (sync, active high), trig (one-clock request),
//        pulse (high for exactly WIDTH clocks starting the clock after trig).
// Triggers that arrive while a pulse is running are ignored.
module ccd_ofd_pulse
  import ccd_timing_pkg::*;
#(
  parameter int WIDTH = OFD_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic pulse
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse <= 1'b0;
      cnt   <= '0;
    end else if (!pulse) begin
      if (trig) begin
        pulse <= 1'b1;
        cnt   <= '0;
      end
    end else if (cnt == CW'(WIDTH - 1)) begin
      pulse <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ccd_vtiming_gen.sv
// CCD vertical timing generator: per frame an XSG readout pulse framed by
// XV hold guards, then one 4-phase vertical transfer per accepted line strobe.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_frame_start       starts a frame (accepted only when idle)
//   i_line_start        per-line strobe (accepted only in LINE_WAIT)
//   iv_line_num         lines this frame, latched on frame acceptance
//   i_ofd_trig          shutter pulse request
//   ov_xv, o_xsg, o_ofd vertical driver outputs (o_xsg active low)
//   o_busy, ov_line_cnt, o_line_err  status
// Optional: define CCD_OFD_EN to build the OFD shutter pulse; otherwise
// o_ofd is tied low and i_ofd_trig is unused.
module ccd_vtiming_gen
  import ccd_timing_pkg::*;
#(
  parameter int XV_STEP   = XV_STEP_DEF,
  parameter int XSG_WIDTH = XSG_WIDTH_DEF,
  parameter int XSG_GUARD = XSG_GUARD_DEF,
  parameter int OFD_WIDTH = OFD_WIDTH_DEF,
  parameter int LINE_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_frame_start,
  input  logic              i_line_start,
  input  logic [LINE_W-1:0] iv_line_num,
  input  logic              i_ofd_trig,
  output logic [3:0]        ov_xv,
  output logic              o_xsg,
  output logic              o_ofd,
  output logic              o_busy,
  output logic [LINE_W-1:0] ov_line_cnt,
  output logic              o_line_err
);

  localparam int DMAX  = max3(XV_STEP, XSG_WIDTH, XSG_GUARD);
  localparam int DUR_W = (DMAX > 1) ? $clog2(DMAX) : 1;

  state_t            state, n_state;
  logic [DUR_W-1:0]  dur, n_dur;
  logic [2:0]        step, n_step;
  logic [LINE_W-1:0] line_tgt;
  logic              accept, line_inc;
  logic [3:0]        n_xv;
  logic              n_xsg, n_busy, n_err;

  // Saturating increment: the counter can never roll over even if a limit
  // parameter is misconfigured larger than the counter range.
  function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    n_state  = state;
    n_dur    = dur;
    n_step   = step;
    accept   = 1'b0;
    line_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_frame_start) begin
          accept  = 1'b1;
          n_state = ST_XSG_PRE;
          n_dur   = '0;
        end
      end
      ST_XSG_PRE: begin
        if (dur == DUR_W'(XSG_GUARD - 1)) begin
          n_state = ST_XSG_ACT;
          n_dur   = '0;
        end else n_dur = sat_inc(dur);
      end
      ST_XSG_ACT: begin
        if (dur == DUR_W'(XSG_WIDTH - 1)) begin
          n_state = ST_XSG_POST;
          n_dur   = '0;
        end else n_dur = sat_inc(dur);
      end
      ST_XSG_POST: begin
        if (dur == DUR_W'(XSG_GUARD - 1)) begin
          n_state = (line_tgt == '0) ? ST_IDLE : ST_LINE_WAIT;
          n_dur   = '0;
        end else n_dur = sat_inc(dur);
      end
      ST_LINE_WAIT: begin
        if (i_line_start) begin
          n_state = ST_VSHIFT;
          n_step  = '0;
          n_dur   = '0;
        end
      end
      ST_VSHIFT: begin
        if (dur == DUR_W'(XV_STEP - 1)) begin
          n_dur = '0;
          if (step == 3'd7) begin
            line_inc = 1'b1;
            n_step   = '0;
            // Compare against the latched target so a full-scale count ends
            // the frame instead of wrapping.
            n_state  = ((ov_line_cnt + 1'b1) == line_tgt) ? ST_IDLE : ST_LINE_WAIT;
          end else n_step = step + 1'b1;
        end else n_dur = sat_inc(dur);
      end
      default: n_state = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    n_xv   = (n_state == ST_VSHIFT) ? XV_PAT[n_step] : XV_IDLE;
    n_xsg  = (n_state != ST_XSG_ACT);
    n_busy = (n_state != ST_IDLE);
    // A strobe landing on the VSHIFT exit edge is still seen in VSHIFT, so it
    // is dropped and flagged here as well.
    n_err  = i_line_start && (state != ST_IDLE) && (state != ST_LINE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      dur         <= '0;
      step        <= '0;
      line_tgt    <= '0;
      ov_line_cnt <= '0;
      ov_xv       <= XV_IDLE;
      o_xsg       <= 1'b1;
      o_busy      <= 1'b0;
      o_line_err  <= 1'b0;
    end else begin
      state      <= n_state;
      dur        <= n_dur;
      step       <= n_step;
      ov_xv      <= n_xv;
      o_xsg      <= n_xsg;
      o_busy     <= n_busy;
      o_line_err <= n_err;
      if (accept) begin
        line_tgt    <= iv_line_num;
        ov_line_cnt <= '0;
      end else if (line_inc) begin
        ov_line_cnt <= ov_line_cnt + 1'b1;
      end
    end
  end

`ifdef CCD_OFD_EN
  logic ofd_req;
  assign ofd_req = i_ofd_trig && ((state == ST_IDLE) || (state == ST_LINE_WAIT));

  ccd_ofd_pulse #(.WIDTH(OFD_WIDTH)) u_ofd (
    .clk  (clk),
    .reset(reset),
    .trig (ofd_req),
    .pulse(o_ofd)
  );
`else
  logic unused_ofd;
  assign unused_ofd = i_ofd_trig ^ (OFD_WIDTH != 0);
  assign o_ofd      = 1'b0;
`endif

endmodule

// File: tb/tb_ccd_vtiming_gen.sv
// Directed bench for ccd_vtiming_gen. A second instance with one-clock
// transfer steps covers the full-scale line count in a short run.
module tb_ccd_vtiming_gen;

  localparam int LW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, frame_start, line_start, ofd_trig;
  logic [LW-1:0] line_num;
  logic [3:0]    xv;
  logic          xsg, ofd, busy, line_err;
  logic [LW-1:0] line_cnt;

  logic          f_frame, f_line, f_trig;
  logic [LW-1:0] f_num;
  logic [3:0]    f_xv;
  logic          f_xsg, f_ofd, f_busy, f_err;
  logic [LW-1:0] f_cnt;

  ccd_vtiming_gen dut (
    .clk(clk), .reset(reset), .i_frame_start(frame_start), .i_line_start(line_start),
    .iv_line_num(line_num), .i_ofd_trig(ofd_trig), .ov_xv(xv), .o_xsg(xsg),
    .o_ofd(ofd), .o_busy(busy), .ov_line_cnt(line_cnt), .o_line_err(line_err)
  );

  ccd_vtiming_gen #(.XV_STEP(1)) dut_f (
    .clk(clk), .reset(reset), .i_frame_start(f_frame), .i_line_start(f_line),
    .iv_line_num(f_num), .i_ofd_trig(f_trig), .ov_xv(f_xv), .o_xsg(f_xsg),
    .o_ofd(f_ofd), .o_busy(f_busy), .ov_line_cnt(f_cnt), .o_line_err(f_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] pat [8] = '{4'b1100, 4'b1110, 4'b0110, 4'b0111,
                          4'b0011, 4'b1011, 4'b1001, 4'b1101};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, hi, lo, bad;
    logic [LW-1:0] prev;
    reset = 1; frame_start = 0; line_start = 0; ofd_trig = 0; line_num = '0;
    f_frame = 0; f_line = 0; f_trig = 0; f_num = '0;
    tick(); tick();
    chk("rst_xv",   32'(xv), 'hC);
    chk("rst_xsg",  32'(xsg), 1);
    chk("rst_ofd",  32'(ofd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt",  32'(line_cnt), 0);
    chk("rst_err",  32'(line_err), 0);
    reset = 0;
    tick();

    // Two-line frame
    line_num = 2; frame_start = 1; tick(); frame_start = 0;
    chk("busy_rise", 32'(busy), 1);
    k = 0;
    while (xsg && k < 20) begin tick(); k++; end
    chk("xsg_lead", k, 8);
    k = 0;
    while (!xsg && k < 40) begin tick(); k++; end
    chk("xsg_width", k, 16);
    repeat (8) tick();
    chk("post_xv", 32'(xv), 'hC);
    chk("post_busy", 32'(busy), 1);
    for (int ln = 0; ln < 2; ln++) begin
      line_start = 1; tick(); line_start = 0;
      bad = 0;
      for (int s = 0; s < 8; s++) begin
        for (int d = 0; d < 4; d++) begin
          if (xv !== pat[s]) bad++;
          if (ln == 0 && s == 2 && d == 0) begin line_num = 7; frame_start = 1; end
          if (ln == 0 && s == 7 && d == 3) line_start = 1;
          if (ln == 1 && s == 4 && d == 0) line_start = 1;
          if (ln == 1 && s == 4 && d == 1) chk("err_pulse", 32'(line_err), 1);
          if (ln == 1 && s == 4 && d == 2) chk("err_clear", 32'(line_err), 0);
          tick();
          frame_start = 0; line_start = 0;
        end
      end
      chk("xv_seq", bad, 0);
      chk("end_xv", 32'(xv), 'hC);
      chk("end_cnt", 32'(line_cnt), ln + 1);
      chk("end_busy", 32'(busy), (ln == 0) ? 1 : 0);
      if (ln == 0) begin
        chk("sameedge_err", 32'(line_err), 1);
        tick();
        chk("sameedge_noshift", 32'(xv), 'hC);
        chk("sameedge_errclr", 32'(line_err), 0);
      end
    end

    // Zero-line frame: XSG only
    line_num = 0; frame_start = 1; tick(); frame_start = 0;
    chk("z_cnt_clr", 32'(line_cnt), 0);
    lo = 0;
    for (int j = 1; j <= 32; j++) begin
      if (!xsg) lo++;
      if (j == 31) chk("z_busy_hold", 32'(busy), 1);
      tick();
    end
    chk("z_busy_drop", 32'(busy), 0);
    chk("z_xsg_width", lo, 16);
    line_start = 1; tick(); line_start = 0;
    chk("z_idle_noerr", 32'(line_err), 0);
    bad = 0;
    repeat (10) begin if (xv !== 4'b1100) bad++; tick(); end
    chk("z_idle_noxv", bad, 0);

    // Reset in the middle of a transfer
    line_num = 3; frame_start = 1; tick(); frame_start = 0;
    repeat (32) tick();
    line_start = 1; tick(); line_start = 0;
    repeat (32) tick();
    chk("r_cnt1", 32'(line_cnt), 1);
    line_start = 1; tick(); line_start = 0;
    repeat (13) tick();
    chk("r_step3", 32'(xv), 'h7);
    reset = 1; tick();
    chk("r_xv", 32'(xv), 'hC);
    chk("r_xsg", 32'(xsg), 1);
    chk("r_busy", 32'(busy), 0);
    chk("r_cnt", 32'(line_cnt), 0);
    chk("r_ofd", 32'(ofd), 0);
    reset = 0; tick();

`ifdef CCD_OFD_EN
    ofd_trig = 1; tick(); ofd_trig = 0;
    chk("ofd_start", 32'(ofd), 1);
    hi = 0;
    for (int j = 1; j <= 40; j++) begin
      if (ofd) hi++;
      if (j == 10) ofd_trig = 1;
      tick();
      ofd_trig = 0;
    end
    chk("ofd_width", hi, 32);
    line_num = 0; frame_start = 1; tick(); frame_start = 0;
    repeat (12) tick();
    ofd_trig = 1; tick(); ofd_trig = 0;
    hi = 0;
    repeat (40) begin if (ofd) hi++; tick(); end
    chk("ofd_xsg_ignored", hi, 0);
`else
    ofd_trig = 1; repeat (5) tick(); ofd_trig = 0;
    hi = 0;
    repeat (40) begin if (ofd) hi++; tick(); end
    chk("ofd_off", hi, 0);
`endif

    // Full-scale line count on the fast instance
    f_num = 12'd4095; f_frame = 1; tick(); f_frame = 0;
    f_line = 1;
    k = 0; bad = 0; prev = '0;
    while (f_busy && k < 60000) begin
      tick(); k++;
      if (f_cnt < prev) bad++;
      prev = f_cnt;
    end
    f_line = 0;
    chk("f_timeout", (k < 60000) ? 1 : 0, 1);
    chk("f_nowrap", bad, 0);
    chk("f_cnt", 32'(f_cnt), 4095);
    chk("f_idle", 32'(f_busy), 0);
    tick();
    chk("f_xv_idle", 32'(f_xv), 'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ccd_vtiming_gen.md
Name: ccd_vtiming_gen

Overview:
- FPGA-side CCD vertical timing generator that produces the XV[3:0], XSG and OFD drive signals consumed by the CXD3400-class vertical driver.
- Per frame it issues a sensor-gate (XSG) readout pulse with guard intervals, then one 4-phase vertical transfer per horizontal line-start strobe, for a latched number of lines.
- Sits between the horizontal timing / frame controller and the vertical driver pins.

Parameters:
- XV_STEP, 4: clocks per vertical-transfer step (8 steps per line).
- XSG_WIDTH, 16: clocks XSG is held active.
- XSG_GUARD, 8: clocks of XV hold before and after the XSG pulse.
- OFD_WIDTH, 32: clocks per OFD (electronic shutter) pulse.
- LINE_W, 12: width of the line count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_frame_start  in  1  one-clock strobe that starts a frame sequence.
- i_line_start  in  1  one-clock strobe per horizontal line.
- iv_line_num  in  LINE_W  lines to transfer this frame; latched on an accepted i_frame_start.
- i_ofd_trig  in  1  one-clock request for an OFD shutter pulse.
- ov_xv  out  4  vertical transfer phases.
- o_xsg  out  1  sensor gate, active low.
- o_ofd  out  1  overflow-drain shutter pulse, active high.
- o_busy  out  1  frame sequence in progress.
- ov_line_cnt  out  LINE_W  lines completed in the current frame.
- o_line_err  out  1  one-clock pulse when i_line_start is dropped.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: ov_xv=4'b1100, o_xsg=1, o_ofd=0, o_busy=0, ov_line_cnt=0, o_line_err=0, FSM=IDLE. A reset mid-operation returns every output to these values on the same edge and aborts any OFD pulse.
- FSM states: IDLE, XSG_PRE, XSG_ACT, XSG_POST, LINE_WAIT, VSHIFT.
- IDLE:
  - i_frame_start latches iv_line_num, clears ov_line_cnt and moves to XSG_PRE.
  - o_busy=1 from the next clock.
- XSG_PRE: XSG_GUARD clocks, ov_xv held at 1100.
- XSG_ACT: XSG_WIDTH clocks with o_xsg=0. o_xsg returns to 1 on the first clock of XSG_POST.
- XSG_POST: XSG_GUARD clocks, then go to LINE_WAIT. If the latched line count is 0, go to IDLE instead (o_busy=0).
- LINE_WAIT: i_line_start moves the FSM to VSHIFT.
- VSHIFT:
  - 8 steps of XV_STEP clocks each.
  - Step patterns 0..7: 1100, 1110, 0110, 0111, 0011, 1011, 1001, 1101.
  - Step 0 output appears the clock after acceptance; after step 7, ov_xv returns to 1100.
  - ov_line_cnt increments on the VSHIFT exit clock.
  - If the new count equals the latched value, go to IDLE (o_busy=0); otherwise go to LINE_WAIT.
  - Line latency: 8*XV_STEP clocks.
- Ignored and dropped strobes:
  - i_frame_start while o_busy=1 is ignored.
  - i_line_start in any state other than LINE_WAIT (while busy) raises o_line_err for one clock and is otherwise ignored.
  - i_line_start in IDLE is ignored silently.
- Same-edge events: when VSHIFT ends on the same edge as an i_line_start, the strobe is dropped and flagged.
- Counters: step and duration counters saturate internally. ov_line_cnt never wraps because the comparison uses the latched value; a value of 2^LINE_W-1 is legal.

Optional Feature:
- Macro: CCD_OFD_EN.
- Defined:
  - i_ofd_trig in IDLE or LINE_WAIT starts an OFD pulse of exactly OFD_WIDTH clocks, o_ofd=1 from the next clock.
  - Triggers during an active pulse or during XSG_PRE/XSG_ACT/XSG_POST are ignored.
  - A pulse in progress when the FSM leaves LINE_WAIT completes normally.
- Undefined: o_ofd is constant 0, i_ofd_trig is unused, and no OFD counter is synthesized.

Decomposition:
- Shared package ccd_timing_pkg:
  - FSM state encoding.
  - XV step pattern table (8 entries x 4 bits).
  - XV_IDLE=4'b1100.
  - Default XV_STEP/XSG_WIDTH/XSG_GUARD/OFD_WIDTH values.
- One sub-module: ccd_ofd_pulse (trigger-to-fixed-width pulse generator), instantiated only under CCD_OFD_EN.

Test Plan:
- Reset → ov_xv=1100, o_xsg=1, o_ofd=0, o_busy=0. Assert reset during step 3 of VSHIFT → all idle values on that edge, ov_line_cnt=0.
- i_frame_start with iv_line_num=2 → o_xsg low for exactly 16 clocks, starting 8 clocks after busy rises. Two i_line_start strobes → two 32-clock XV sequences in the stated pattern order, ov_line_cnt 1 then 2, o_busy falls on the last VSHIFT exit.
- iv_line_num=0 → XSG pulse only; o_busy drops after XSG_POST; any later i_line_start causes no XV activity.
- i_line_start during VSHIFT step 4 → o_line_err pulses one clock, sequence unaffected, ov_line_cnt increments once. i_frame_start while busy → ignored.
- CCD_OFD_EN defined: i_ofd_trig in IDLE → o_ofd high exactly 32 clocks; retrigger at clock 10 → no extension; trigger during XSG_ACT → ignored. Undefined: o_ofd stays 0 throughout.
- iv_line_num=4095 with fast line strobes → ov_line_cnt reaches 4095 without wrap, then FSM returns to IDLE.
